// File: rtl/uart_seg_buffer.sv
// Multi-digit nibble shift buffer fed by uart_rx bytes (raw or ASCII-hex entry),
// decoded to registered seven-segment patterns with leading-zero and idle blanking.
module uart_seg_buffer #(
  parameter int unsigned NUM_BYTES      = 1,
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter bit          LZ_SUPPRESS    = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter logic [7:0]  RESET_VALUE    = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                i_data,
  input  logic                      i_valid,
  input  logic                      i_mode,
  output logic [14*NUM_BYTES-1:0]   o_seg,
  output logic                      o_err,
  output logic                      o_blank
);

  localparam int unsigned NumDigits = 2 * NUM_BYTES;
  localparam int unsigned BufW      = 4 * NumDigits;
  localparam int unsigned SegW      = 7 * NumDigits;
  localparam int unsigned CntW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(TIMEOUT_CYCLES);
  localparam logic [BufW-1:0] ResetBuf = BufW'(RESET_VALUE);

  function automatic logic [6:0] decode_hex(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  // Walk from the top digit down so upper_zero tracks "this digit and all above are zero".
  function automatic logic [SegW-1:0] render(input logic [BufW-1:0] b, input logic blank);
    logic [SegW-1:0] seg;
    logic [3:0]      nib;
    logic            upper_zero;
    seg        = '0;
    upper_zero = 1'b1;
    for (int k = NumDigits - 1; k >= 0; k--) begin
      nib        = b[4*k +: 4];
      upper_zero = upper_zero && (nib == 4'h0);
      if (!blank && !(LZ_SUPPRESS && upper_zero && (k != 0))) begin
        seg[7*k +: 7] = decode_hex(nib);
      end
    end
    return ACTIVE_LOW ? ~seg : seg;
  endfunction

  // Returns {valid, value} for an ASCII hex digit.
  function automatic logic [4:0] ascii_hex(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      return {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      return {1'b1, c[3:0] + 4'd9};
    end
    return 5'b0;
  endfunction

  logic [BufW-1:0] buf_q, buf_d;
  logic [SegW-1:0] seg_q, seg_d;
  logic [CntW-1:0] idle_q, idle_d;
  logic            err_q, err_d;
  logic            blank_q, blank_d;
  logic [4:0]      hex;

  always_comb begin
    buf_d  = buf_q;
    err_d  = 1'b0;
    idle_d = idle_q;
    hex    = ascii_hex(i_data);
    if (i_valid) begin
      idle_d = '0;
      if (!i_mode) begin
        buf_d = (buf_q << 8) | BufW'(i_data);
      end else if (hex[4]) begin
        buf_d = (buf_q << 4) | BufW'(hex[3:0]);
      end else if (i_data == 8'h0D || i_data == 8'h0A) begin
        buf_d = '0;
      end else if (i_data == 8'h08) begin
        buf_d = buf_q >> 4;
      end else begin
        err_d = 1'b1;
      end
    end else if (idle_q != CntMax) begin
      idle_d = idle_q + 1'b1;
    end
    blank_d = (TIMEOUT_CYCLES != 0) && (idle_d == CntMax);
    // Blanking takes effect on o_seg together with o_blank; buffer changes lag one edge.
    seg_d   = render(buf_q, blank_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= ResetBuf;
      seg_q   <= render(ResetBuf, 1'b0);
      idle_q  <= '0;
      err_q   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      seg_q   <= seg_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      blank_q <= blank_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_err   = err_q;
  assign o_blank = blank_q;

endmodule

// File: tb/tb_uart_seg_buffer.sv
// Scoreboard bench for uart_seg_buffer: 2 bytes, active-low, LZ suppression,
// 10-cycle timeout, reset value 0x05.
module tb_uart_seg_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_mode;
  logic [27:0] o_seg;
  logic        o_err;
  logic        o_blank;

  uart_seg_buffer #(
    .NUM_BYTES     (2),
    .ACTIVE_LOW    (1'b1),
    .LZ_SUPPRESS   (1'b1),
    .TIMEOUT_CYCLES(10),
    .RESET_VALUE   (8'h05)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_mode (i_mode),
    .o_seg  (o_seg),
    .o_err  (o_err),
    .o_blank(o_blank)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          seg_idx  = 0;
  int          err_idx  = 0;
  logic [27:0] seg_exp[$];
  logic        err_exp[$];
  logic        v1 = 1'b0;
  logic        v2 = 1'b0;
  logic [27:0] es;
  logic        ee;

  localparam logic [27:0] AllOff = 28'hFFFFFFF;

  // Expected pattern from active-high digit codes (3..0); 7'h00 = blank.
  function automatic logic [27:0] al(input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return ~{d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic m, input logic [27:0] exp_seg,
                      input logic exp_err);
    i_data  = d;
    i_mode  = m;
    i_valid = 1'b1;
    seg_exp.push_back(exp_seg);
    err_exp.push_back(exp_err);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Strobe tracking: o_err is due one edge after the strobe, o_seg two edges after.
  always @(posedge clk) begin
    v1 <= i_valid && !rst;
    v2 <= v1 && !rst;
  end

  always @(negedge clk) begin
    if (v1) begin
      if (err_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL err_queue: got empty expected entry");
      end else begin
        ee = err_exp.pop_front();
        check($sformatf("err[%0d]", err_idx), {27'b0, o_err}, {27'b0, ee});
        err_idx++;
      end
    end
    if (v2) begin
      if (seg_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL seg_queue: got empty expected entry");
      end else begin
        es = seg_exp.pop_front();
        check($sformatf("seg[%0d]", seg_idx), o_seg, es);
        check($sformatf("blank_after[%0d]", seg_idx), {27'b0, o_blank}, 28'd0);
        seg_idx++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_mode  = 1'b0;
    i_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_seg", o_seg, al(7'h00, 7'h00, 7'h00, 7'h5B));
    check("reset_err", {27'b0, o_err}, 28'd0);
    check("reset_blank", {27'b0, o_blank}, 28'd0);

    // Raw byte mode
    send(8'h12, 1'b0, al(7'h00, 7'h5B, 7'h30, 7'h6D), 1'b0);
    send(8'h3F, 1'b0, al(7'h30, 7'h6D, 7'h79, 7'h47), 1'b0);
    // ASCII entry mode, including range-edge rejects and editing characters
    send(8'h41, 1'b1, al(7'h6D, 7'h79, 7'h47, 7'h77), 1'b0);
    send(8'h62, 1'b1, al(7'h79, 7'h47, 7'h77, 7'h1F), 1'b0);
    send(8'h37, 1'b1, al(7'h47, 7'h77, 7'h1F, 7'h70), 1'b0);
    send(8'h5A, 1'b1, al(7'h47, 7'h77, 7'h1F, 7'h70), 1'b1);
    send(8'h2F, 1'b1, al(7'h47, 7'h77, 7'h1F, 7'h70), 1'b1);
    send(8'h47, 1'b1, al(7'h47, 7'h77, 7'h1F, 7'h70), 1'b1);
    send(8'h08, 1'b1, al(7'h00, 7'h47, 7'h77, 7'h1F), 1'b0);
    send(8'h0D, 1'b1, al(7'h00, 7'h00, 7'h00, 7'h7E), 1'b0);
    send(8'h30, 1'b1, al(7'h00, 7'h00, 7'h00, 7'h7E), 1'b0);
    send(8'h35, 1'b1, al(7'h00, 7'h00, 7'h00, 7'h5B), 1'b0);
    send(8'h30, 1'b1, al(7'h00, 7'h00, 7'h5B, 7'h7E), 1'b0);
    send(8'h39, 1'b1, al(7'h00, 7'h5B, 7'h7E, 7'h7B), 1'b0);
    send(8'h66, 1'b1, al(7'h5B, 7'h7E, 7'h7B, 7'h47), 1'b0);
    send(8'h0A, 1'b1, al(7'h00, 7'h00, 7'h00, 7'h7E), 1'b0);
    send(8'h61, 1'b1, al(7'h00, 7'h00, 7'h00, 7'h77), 1'b0);
    send(8'h40, 1'b1, al(7'h00, 7'h00, 7'h00, 7'h77), 1'b1);
    send(8'h67, 1'b1, al(7'h00, 7'h00, 7'h00, 7'h77), 1'b1);
    // Back-to-back raw bytes
    send(8'h01, 1'b0, al(7'h00, 7'h77, 7'h7E, 7'h30), 1'b0);
    send(8'h02, 1'b0, al(7'h00, 7'h30, 7'h7E, 7'h6D), 1'b0);
    send(8'h03, 1'b0, al(7'h00, 7'h6D, 7'h7E, 7'h79), 1'b0);
    send(8'h04, 1'b0, al(7'h00, 7'h79, 7'h7E, 7'h33), 1'b0);

    // Mode change without a strobe leaves the buffer alone
    i_mode = 1'b1;
    repeat (3) @(negedge clk);
    check("mode_only", o_seg, al(7'h00, 7'h79, 7'h7E, 7'h33));
    i_mode = 1'b0;

    // Inactivity blanking and saturation
    send(8'h08, 1'b0, al(7'h00, 7'h33, 7'h7E, 7'h7F), 1'b0);
    repeat (9) @(negedge clk);
    check("blank_pre", {27'b0, o_blank}, 28'd0);
    @(negedge clk);
    check("blank_on", {27'b0, o_blank}, 28'd1);
    check("blank_seg", o_seg, AllOff);
    repeat (10) @(negedge clk);
    check("blank_hold", {27'b0, o_blank}, 28'd1);
    check("blank_hold_seg", o_seg, AllOff);
    send(8'h21, 1'b0, al(7'h00, 7'h7F, 7'h6D, 7'h30), 1'b0);
    check("blank_clear", {27'b0, o_blank}, 28'd0);
    @(negedge clk);
    repeat (12) @(negedge clk);
    check("blank_again", {27'b0, o_blank}, 28'd1);

    // Reset wins over a simultaneous strobe
    rst     = 1'b1;
    i_valid = 1'b1;
    i_mode  = 1'b0;
    i_data  = 8'h55;
    @(negedge clk);
    rst     = 1'b0;
    i_valid = 1'b0;
    check("rst_valid_seg", o_seg, al(7'h00, 7'h00, 7'h00, 7'h5B));
    check("rst_valid_err", {27'b0, o_err}, 28'd0);
    check("rst_valid_blank", {27'b0, o_blank}, 28'd0);
    send(8'h33, 1'b1, al(7'h00, 7'h00, 7'h5B, 7'h79), 1'b0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (seg_exp.size() != 0 || err_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", seg_exp.size(), err_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
